// File: rtl/control_unit.sv
// control_unit: instruction decoder and sequencing control for the 16-bit
// accumulator CPU. All control outputs are combinational; the only state is
// a halt latch that is set by HLT and cleared only by reset.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        ready,
  input  logic [3:0]  flags,
  output logic        branch,
  output logic        ret,
  output logic        loadPC,
  output logic        push,
  output logic        op_stack,
  output logic [4:0]  opsel,
  output logic [1:0]  sel_srcA,
  output logic [1:0]  sel_srcB,
  output logic [1:0]  data_addr_sel,
  output logic        wr_to_data_mem,
  output logic [1:0]  mem_data_wr_sel,
  output logic        reg_from_mem,
  output logic        extra_write_X,
  output logic        wr_X,
  output logic        wr_Y,
  output logic        wr_ACC,
  output logic        save_flags
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_CMP  = 5'b00110;
  localparam logic [4:0] OP_TST  = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_MOD  = 5'b01110;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       w_hlt;
  logic       w_multi;
  logic       w_cond;
  logic [3:0] w_sub;
  logic [1:0] w_reg;
  logic       w_unused;

  assign w_hlt    = (instr[15:10] == 6'b000001);
  assign w_sub    = instr[13:10];
  assign w_reg    = instr[9:8];
  assign w_multi  = (instr[13:9] == OP_MUL) || (instr[13:9] == OP_DIV) ||
                    (instr[13:9] == OP_MOD);
  // Low instruction bits carry no control information.
  assign w_unused = &{1'b0, instr[4:0]};

  // Halt latch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Halt latch next state: enter on HLT, never leave except by reset.
  always_comb begin
    w_state_nxt = r_state;
    if (w_hlt) w_state_nxt = ST_HALT;
  end

  // Branch condition from the stored flags {Z,N,C,V}.
  always_comb begin
    w_cond = 1'b0;
    case (w_sub)
      4'b0000: w_cond = 1'b1;
      4'b0001: w_cond = flags[3];
      4'b0010: w_cond = ~flags[3];
      4'b0011: w_cond = flags[2];
      4'b0100: w_cond = ~flags[2];
      4'b0101: w_cond = flags[1];
      4'b0110: w_cond = ~flags[1];
      4'b0111: w_cond = flags[0];
      4'b1000: w_cond = ~flags[0];
      default: w_cond = 1'b0;
    endcase
  end

  // Control decode.
  always_comb begin
    branch          = 1'b0;
    ret             = 1'b0;
    loadPC          = 1'b1;
    push            = 1'b0;
    op_stack        = 1'b0;
    opsel           = 5'b00000;
    sel_srcA        = 2'b00;
    sel_srcB        = 2'b00;
    data_addr_sel   = 2'b00;
    wr_to_data_mem  = 1'b0;
    mem_data_wr_sel = 2'b00;
    reg_from_mem    = 1'b0;
    extra_write_X   = 1'b0;
    wr_X            = 1'b0;
    wr_Y            = 1'b0;
    wr_ACC          = 1'b0;
    save_flags      = 1'b0;
    if (!rst_n || w_hlt || (r_state == ST_HALT)) begin
      loadPC = 1'b0;
    end else begin
      case (instr[15:14])
        2'b01: begin
          opsel    = instr[13:9];
          sel_srcA = instr[8:7];
          sel_srcB = instr[6:5];
          if (w_multi && !ready) begin
            loadPC = 1'b0;
          end else begin
            save_flags    = 1'b1;
            wr_ACC        = (instr[13:9] != OP_CMP) && (instr[13:9] != OP_TST);
            extra_write_X = (instr[13:9] == OP_MUL);
          end
        end
        2'b10: begin
          if (w_sub <= 4'b1001) data_addr_sel = w_reg;
          case (w_sub)
            4'b0000: begin reg_from_mem = 1'b1; wr_ACC = 1'b1; end
            4'b0001: begin reg_from_mem = 1'b1; wr_X   = 1'b1; end
            4'b0010: begin reg_from_mem = 1'b1; wr_Y   = 1'b1; end
            4'b0011: begin wr_to_data_mem = 1'b1; mem_data_wr_sel = 2'b00; end
            4'b0100: begin wr_to_data_mem = 1'b1; mem_data_wr_sel = 2'b01; end
            4'b0101: begin wr_to_data_mem = 1'b1; mem_data_wr_sel = 2'b10; end
            4'b0110: begin opsel = OP_PASS; sel_srcA = 2'b00; wr_X   = 1'b1; end
            4'b0111: begin opsel = OP_PASS; sel_srcA = 2'b00; wr_Y   = 1'b1; end
            4'b1000: begin opsel = OP_PASS; sel_srcA = 2'b01; wr_ACC = 1'b1; end
            4'b1001: begin opsel = OP_PASS; sel_srcA = 2'b10; wr_ACC = 1'b1; end
            4'b1010: begin
              if (w_reg != 2'b11) begin
                op_stack        = 1'b1;
                push            = 1'b1;
                wr_to_data_mem  = 1'b1;
                data_addr_sel   = 2'b11;
                mem_data_wr_sel = w_reg;
              end
            end
            4'b1011: begin
              if (w_reg != 2'b11) begin
                op_stack      = 1'b1;
                data_addr_sel = 2'b11;
                reg_from_mem  = 1'b1;
                wr_ACC        = (w_reg == 2'b00);
                wr_X          = (w_reg == 2'b01);
                wr_Y          = (w_reg == 2'b10);
              end
            end
            default: ;
          endcase
        end
        2'b11: begin
          case (w_sub)
            4'b1001: begin
              branch          = 1'b1;
              op_stack        = 1'b1;
              push            = 1'b1;
              wr_to_data_mem  = 1'b1;
              data_addr_sel   = 2'b11;
              mem_data_wr_sel = 2'b11;
            end
            4'b1010: begin
              ret           = 1'b1;
              op_stack      = 1'b1;
              data_addr_sel = 2'b11;
            end
            default: branch = w_cond;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes expected control
// vectors from a mnemonic-level reference model; a monitor pops and compares.
module tb_control_unit;

  typedef struct packed {
    logic       branch;
    logic       ret;
    logic       loadPC;
    logic       push;
    logic       op_stack;
    logic [4:0] opsel;
    logic [1:0] sel_srcA;
    logic [1:0] sel_srcB;
    logic [1:0] data_addr_sel;
    logic       wr_to_data_mem;
    logic [1:0] mem_data_wr_sel;
    logic       reg_from_mem;
    logic       extra_write_X;
    logic       wr_X;
    logic       wr_Y;
    logic       wr_ACC;
    logic       save_flags;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    string tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        ready = 1'b0;
  logic [3:0]  flags = 4'h0;
  logic        branch, ret, loadPC, push, op_stack;
  logic [4:0]  opsel;
  logic [1:0]  sel_srcA, sel_srcB, data_addr_sel, mem_data_wr_sel;
  logic        wr_to_data_mem, reg_from_mem, extra_write_X;
  logic        wr_X, wr_Y, wr_ACC, save_flags;

  sb_t q[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  m_halted = 1'b0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .ready(ready), .flags(flags),
    .branch(branch), .ret(ret), .loadPC(loadPC), .push(push),
    .op_stack(op_stack), .opsel(opsel), .sel_srcA(sel_srcA),
    .sel_srcB(sel_srcB), .data_addr_sel(data_addr_sel),
    .wr_to_data_mem(wr_to_data_mem), .mem_data_wr_sel(mem_data_wr_sel),
    .reg_from_mem(reg_from_mem), .extra_write_X(extra_write_X),
    .wr_X(wr_X), .wr_Y(wr_Y), .wr_ACC(wr_ACC), .save_flags(save_flags)
  );

  function automatic logic [15:0] mk(input logic [1:0] grp, input logic [3:0] sub,
                                     input logic [9:0] low);
    return {grp, sub, low};
  endfunction

  // Reference model: register index 0=ACC, 1=X, 2=Y.
  function automatic void set_wr(inout ctl_t e, input int idx);
    if (idx == 0) e.wr_ACC = 1'b1;
    if (idx == 1) e.wr_X   = 1'b1;
    if (idx == 2) e.wr_Y   = 1'b1;
  endfunction

  function automatic ctl_t model(input logic rst, input logic [15:0] ins,
                                 input logic rdy, input logic [3:0] flg,
                                 input bit halted);
    ctl_t e;
    int grp, sub, r, op, c;
    logic fbit;
    e = '0;
    grp = int'(ins[15:14]);
    sub = int'(ins[13:10]);
    r   = int'(ins[9:8]);
    op  = int'(ins[13:9]);
    if (!rst || halted || (grp == 0 && sub == 1)) return e;
    e.loadPC = 1'b1;
    if (grp == 1) begin
      e.opsel    = ins[13:9];
      e.sel_srcA = ins[8:7];
      e.sel_srcB = ins[6:5];
      if (op >= 12 && op <= 14 && !rdy) begin
        e.loadPC = 1'b0;
      end else begin
        e.save_flags    = 1'b1;
        e.wr_ACC        = !(op == 6 || op == 7);
        e.extra_write_X = (op == 12);
      end
    end else if (grp == 2) begin
      if (sub <= 9) e.data_addr_sel = 2'(r);
      if (sub <= 2) begin
        e.reg_from_mem = 1'b1;
        set_wr(e, sub);
      end else if (sub <= 5) begin
        e.wr_to_data_mem  = 1'b1;
        e.mem_data_wr_sel = 2'(sub - 3);
      end else if (sub <= 7) begin
        set_wr(e, sub - 5);
      end else if (sub <= 9) begin
        e.sel_srcA = 2'(sub - 7);
        e.wr_ACC   = 1'b1;
      end else if (sub <= 11 && r != 3) begin
        e.op_stack      = 1'b1;
        e.data_addr_sel = 2'b11;
        if (sub == 10) begin
          e.push            = 1'b1;
          e.wr_to_data_mem  = 1'b1;
          e.mem_data_wr_sel = 2'(r);
        end else begin
          e.reg_from_mem = 1'b1;
          set_wr(e, r);
        end
      end
    end else if (grp == 3) begin
      if (sub == 0) begin
        e.branch = 1'b1;
      end else if (sub <= 8) begin
        c = sub - 1;
        fbit = flg[3 - c / 2];
        e.branch = (c % 2 == 0) ? fbit : !fbit;
      end else if (sub == 9) begin
        e.branch = 1'b1; e.op_stack = 1'b1; e.push = 1'b1;
        e.wr_to_data_mem = 1'b1; e.data_addr_sel = 2'b11;
        e.mem_data_wr_sel = 2'b11;
      end else if (sub == 10) begin
        e.ret = 1'b1; e.op_stack = 1'b1; e.data_addr_sel = 2'b11;
      end
    end
    return e;
  endfunction

  task automatic apply(input logic rst, input logic [15:0] ins, input logic rdy,
                       input logic [3:0] flg, input string tag);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n = rst; instr = ins; ready = rdy; flags = flg;
    s.exp = model(rst, ins, rdy, flg, m_halted);
    s.tag = tag;
    q.push_back(s);
    mon_en = 1'b1;
    if (!rst) m_halted = 1'b0;
    else if (ins[15:10] == 6'b000001) m_halted = 1'b1;
  endtask

  // Monitor: compare every presented control vector against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      ctl_t act;
      sb_t  s;
      act = {branch, ret, loadPC, push, op_stack, opsel, sel_srcA, sel_srcB,
             data_addr_sel, wr_to_data_mem, mem_data_wr_sel, reg_from_mem,
             extra_write_X, wr_X, wr_Y, wr_ACC, save_flags};
      n_vec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow got=%07h required=<queued entry>", act);
      end else begin
        s = q.pop_front();
        if (act !== s.exp) begin
          n_fail++;
          $display("FAIL %s instr=%04h rst_n=%0b ready=%0b flags=%04b got=%07h required=%07h",
                   s.tag, instr, rst_n, ready, flags, act, s.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ri;
    int          rr;
    apply(1'b0, 16'h0000, 1'b0, 4'h0, "reset_nop");
    apply(1'b0, mk(2'b11, 4'b1001, 10'h0), 1'b1, 4'hF, "reset_call");
    apply(1'b1, 16'h0000, 1'b0, 4'h0, "nop");
    apply(1'b1, 16'b0100001_00_10_00000, 1'b0, 4'h0, "alu_add");
    apply(1'b1, {2'b01, 5'b01100, 2'b01, 2'b00, 5'h0}, 1'b0, 4'h0, "mul_stall");
    apply(1'b1, {2'b01, 5'b01100, 2'b01, 2'b00, 5'h0}, 1'b1, 4'h0, "mul_ready");
    apply(1'b1, {2'b01, 5'b01101, 2'b11, 2'b11, 5'h0}, 1'b0, 4'h0, "div_stall");
    apply(1'b1, {2'b01, 5'b01110, 2'b10, 2'b01, 5'h0}, 1'b1, 4'h0, "mod_ready");
    apply(1'b1, {2'b01, 5'b00110, 2'b00, 2'b10, 5'h0}, 1'b0, 4'h0, "cmp");
    apply(1'b1, {2'b01, 5'b00111, 2'b01, 2'b01, 5'h0}, 1'b1, 4'h0, "tst");
    apply(1'b1, mk(2'b11, 4'b0001, 10'h0), 1'b0, 4'b1000, "beq_taken");
    apply(1'b1, mk(2'b11, 4'b0001, 10'h0), 1'b0, 4'b0000, "beq_not_taken");
    for (int c = 0; c < 9; c++)
      for (int f = 0; f < 16; f++)
        apply(1'b1, mk(2'b11, 4'(c), 10'(f * 37)), 1'($urandom), 4'(f), "branch_sweep");
    apply(1'b1, mk(2'b11, 4'b1001, 10'h0), 1'b0, 4'h0, "call");
    apply(1'b1, mk(2'b11, 4'b1010, 10'h0), 1'b0, 4'h0, "ret");
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < 4; r++)
        apply(1'b1, mk(2'b10, 4'(s), {2'(r), 8'h5A}), 1'b0, 4'h0, "mem_sweep");
    apply(1'b1, mk(2'b10, 4'b1011, 10'b01_0000_0000), 1'b0, 4'h0, "pop_x");
    apply(1'b1, mk(2'b10, 4'b0101, 10'b01_0000_0000), 1'b0, 4'h0, "sty");
    apply(1'b1, mk(2'b00, 4'b0001, 10'h0), 1'b1, 4'h0, "hlt");
    apply(1'b1, 16'h0000, 1'b1, 4'hF, "halted_nop");
    apply(1'b1, mk(2'b11, 4'b0000, 10'h0), 1'b1, 4'hF, "halted_jmp");
    apply(1'b0, 16'h0000, 1'b0, 4'h0, "reset_pulse");
    apply(1'b1, 16'h0000, 1'b0, 4'h0, "nop_after_reset");
    apply(1'b0, 16'hFFFF, 1'b1, 4'hF, "reset_any");
    for (int i = 0; i < 2000; i++) begin
      rr = int'($urandom_range(0, 99));
      ri = 16'($urandom);
      if (rr < 2 || (m_halted && rr < 25))
        apply(1'b0, ri, 1'($urandom), 4'($urandom), "rand_reset");
      else if (rr < 4)
        apply(1'b1, {6'b000001, ri[9:0]}, 1'($urandom), 4'($urandom), "rand_hlt");
      else
        apply(1'b1, ri, 1'($urandom), 4'($urandom), "rand");
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction decoder and sequencing control for the 16-bit accumulator CPU (registers ACC, X, Y; a data memory shared with the stack).
- Decodes the current 16-bit instruction, together with the ALU `ready` and the stored `flags`, into PC, stack, ALU, memory and register-write controls.
- All outputs are combinational.
- The only state is a halt latch, clocked by `clk` and cleared by the asynchronous reset.

Parameters:
- None. Widths are fixed: instr 16, opsel 5, flags 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  16  current instruction.
- ready  in  1  multicycle ALU result valid.
- flags  in  4  stored flags {Z,N,C,V}: [3]=Z, [2]=N, [1]=C, [0]=V.
- branch  out  1  PC loads branch/call target.
- ret  out  1  PC loads popped return address.
- loadPC  out  1  PC updates this cycle; 0 = stall.
- push  out  1  stack direction: 1 = push, 0 = pop. Valid only when op_stack=1.
- op_stack  out  1  SP update enable.
- opsel  out  5  ALU operation.
- sel_srcA  out  2  ALU A source: 00 ACC, 01 X, 10 Y, 11 memory data.
- sel_srcB  out  2  ALU B source: 00 X, 01 Y, 10 immediate, 11 memory data.
- data_addr_sel  out  2  data address source: 00 immediate, 01 X, 10 Y, 11 SP.
- wr_to_data_mem  out  1  data memory write enable.
- mem_data_wr_sel  out  2  memory write data: 00 ACC, 01 X, 10 Y, 11 PC+1.
- reg_from_mem  out  1  register write data comes from memory, not the ALU.
- extra_write_X  out  1  X written with the ALU high result (MUL).
- wr_X, wr_Y, wr_ACC  out  1 each  register write enables.
- save_flags  out  1  flags register update enable.

Behaviour:
- Default vector: every output 0 except loadPC=1. opsel and all selects are 00000/00 unless an instruction sets them.
- Decode key is instr[15:14]. Any unlisted encoding is a NOP (default vector).
- 00 group:
  - 000000 = NOP.
  - 000001 = HLT.
- 01 group, ALU:
  - opsel=instr[13:9], sel_srcA=instr[8:7], sel_srcB=instr[6:5].
  - Normally drives wr_ACC=1 and save_flags=1.
  - opsel 00110 (CMP) and 00111 (TST): save_flags=1 only, no register write.
  - opsel 01100 (MUL): additionally extra_write_X=1.
  - opsel 01100, 01101 (DIV) and 01110 (MOD) are multicycle. While ready=0: loadPC=0, wr_ACC=0, extra_write_X=0, save_flags=0, with opsel and the selects still driven. When ready=1: normal vector.
  - ready is ignored for all other instructions.
- 10 group, memory (sub-op instr[13:10], address select data_addr_sel=instr[9:8] unless noted):
  - 0000 LDA: reg_from_mem=1, wr_ACC=1.
  - 0001 LDX: reg_from_mem=1, wr_X=1.
  - 0010 LDY: reg_from_mem=1, wr_Y=1.
  - 0011 STA: wr_to_data_mem=1, mem_data_wr_sel=00.
  - 0100 STX: wr_to_data_mem=1, mem_data_wr_sel=01.
  - 0101 STY: wr_to_data_mem=1, mem_data_wr_sel=10.
  - 0110 X<-ACC: opsel=00000 (PASS A), sel_srcA=00, wr_X=1.
  - 0111 Y<-ACC: opsel=00000, sel_srcA=00, wr_Y=1.
  - 1000 ACC<-X: opsel=00000, sel_srcA=01, wr_ACC=1.
  - 1001 ACC<-Y: opsel=00000, sel_srcA=10, wr_ACC=1.
  - 1010 PUSH r: op_stack=1, push=1, wr_to_data_mem=1, data_addr_sel=11, mem_data_wr_sel=instr[9:8]. r = instr[9:8]; 11 is treated as NOP.
  - 1011 POP r: op_stack=1, push=0, data_addr_sel=11, reg_from_mem=1, write enable for r (00 ACC, 01 X, 10 Y). r=11 is treated as NOP.
- 11 group, flow (instr[13:10]). loadPC=1 throughout.
  - Conditional jumps set branch=1 only when the condition holds:
    - 0000 JMP: always.
    - 0001 BEQ: Z. 0010 BNE: !Z.
    - 0011 BMI: N. 0100 BPL: !N.
    - 0101 BCS: C. 0110 BCC: !C.
    - 0111 BVS: V. 1000 BVC: !V.
  - 1001 CALL: branch=1, op_stack=1, push=1, wr_to_data_mem=1, data_addr_sel=11, mem_data_wr_sel=11.
  - 1010 RET: ret=1, op_stack=1, push=0, data_addr_sel=11.
- Halt:
  - Internal halted register, cleared asynchronously when rst_n=0.
  - Set on a rising clk edge when instr is HLT.
  - While instr=HLT or halted=1: default vector with loadPC=0. Other inputs are ignored.
  - Only reset leaves the halted state.
- Reset: while rst_n=0, all outputs are 0, including loadPC=0, regardless of instr.

Test Plan:
- ALU ADD: instr=0100001_00_10_00000 (opsel=00001, srcA=ACC, srcB=imm), ready=0 -> wr_ACC=1, save_flags=1, opsel=00001, sel_srcB=10, loadPC=1.
- MUL stall: opsel=01100, ready=0 -> loadPC=0, wr_ACC=0, extra_write_X=0. Same with ready=1 -> loadPC=1, wr_ACC=1, extra_write_X=1, save_flags=1.
- Branches: BEQ with flags=1000 -> branch=1. BEQ with flags=0000 -> branch=0, loadPC=1. Sweep all 9 conditions over all 16 flag values.
- Stack: CALL -> branch=1, push=1, op_stack=1, wr_to_data_mem=1, data_addr_sel=11, mem_data_wr_sel=11. RET -> ret=1, op_stack=1, push=0. POP X -> reg_from_mem=1, wr_X=1.
- Memory: STY with instr[9:8]=01 -> wr_to_data_mem=1, mem_data_wr_sel=10, data_addr_sel=01, no register write.
- Halt/reset: HLT then clk edge then NOP -> loadPC=0 and all outputs 0. Pulse rst_n=0 -> NOP gives loadPC=1. rst_n=0 with any instr -> all outputs 0.
